stepper_step_sequencer: RTL and testbench

Command-driven step sequencer for the stepper motor controller. It accepts a move command (step count, direction, inter-step delay) and drives the four coil phases one step at a time. Each inter-step wait is paced by handing the delay value to a delay counter (start/delay/enable/done) and waiting for its done flag. It sits between the ASIP instruction datapath and the motor driver pins, and initiates every delay-counter transaction.

---
 rtl/stepper_step_sequencer.sv | 110 +++++++++++
 tb/tb_stepper_step_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_step_sequencer.sv
// stepper_step_sequencer: drives the four coil phases one step per command step, pacing each step through an external delay counter
// Ports: clk, reset (async, active high); cmd_valid/cmd_ready/cmd_steps/cmd_dir/cmd_delay move command;
//        abort; dly_start/dly_value/dly_enable/dly_done delay-counter handshake;
//        phase/step_pulse/busy/position motor-side outputs.
module stepper_step_sequencer #(
    parameter bit HALF_STEP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_steps,
    input  logic        cmd_dir,
    input  logic [7:0]  cmd_delay,
    input  logic        abort,
    output logic        dly_start,
    output logic [7:0]  dly_value,
    output logic        dly_enable,
    input  logic        dly_done,
    output logic [3:0]  phase,
    output logic        step_pulse,
    output logic        busy,
    output logic [15:0] position
);
    typedef enum logic [1:0] {IDLE, STEP, ARM, WAIT} state_t;
    state_t state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] remaining, delay;
    logic       dir;
    logic [3:0] pat;
    logic       accept;

    // zero-step commands are consumed without latching anything
    assign accept     = state == IDLE && cmd_valid && cmd_steps != 8'd0;
    assign cmd_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign dly_start  = state == ARM;
    assign dly_enable = state == WAIT;
    assign dly_value  = delay;

    // full-step keeps idx[2] at 0 and wraps in the low two bits
    assign idx_nx = HALF_STEP ? (dir ? idx + 3'd1 : idx - 3'd1)
                              : {1'b0, dir ? idx[1:0] + 2'd1 : idx[1:0] - 2'd1};

    always_comb begin
        pat = 4'b0000;
        if (HALF_STEP)
            case (idx_nx)
                3'd0: pat = 4'b0001;
                3'd1: pat = 4'b0011;
                3'd2: pat = 4'b0010;
                3'd3: pat = 4'b0110;
                3'd4: pat = 4'b0100;
                3'd5: pat = 4'b1100;
                3'd6: pat = 4'b1000;
                3'd7: pat = 4'b1001;
                default: pat = 4'b0000;
            endcase
        else
            case (idx_nx[1:0])
                2'd0: pat = 4'b0011;
                2'd1: pat = 4'b0110;
                2'd2: pat = 4'b1100;
                2'd3: pat = 4'b1001;
                default: pat = 4'b0000;
            endcase
    end

    // dly_done is only looked at in WAIT; in ARM it still reflects the previous delay
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? STEP : IDLE;
            STEP:    state_nx = abort ? IDLE : ARM;
            ARM:     state_nx = abort ? IDLE : WAIT;
            WAIT:    state_nx = abort ? IDLE : !dly_done ? WAIT : remaining == 8'd0 ? IDLE : STEP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            phase      <= 4'b0000;
            position   <= 16'd0;
            remaining  <= 8'd0;
            dir        <= 1'b0;
            delay      <= 8'd0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            step_pulse <= state == STEP;
            if (accept) begin
                remaining <= cmd_steps;
                dir       <= cmd_dir;
                delay     <= cmd_delay;
            end
            // an abort during STEP still lets the step complete
            if (state == STEP) begin
                idx       <= idx_nx;
                phase     <= pat;
                position  <= dir ? position + 16'd1 : position - 16'd1;
                remaining <= abort ? 8'd0 : remaining - 8'd1;
            end else if (abort && state != IDLE) begin
                remaining <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_stepper_step_sequencer.sv
// tb_stepper_step_sequencer: scoreboard bench for full-step and half-step sequencer instances sharing one delay-counter model
module tb_stepper_step_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_steps = 8'd0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_delay = 8'd0;
    logic        abort = 1'b0;
    logic        dly_done;
    logic        f_ready, f_start, f_enable, f_pulse, f_busy;
    logic [7:0]  f_value;
    logic [3:0]  f_phase;
    logic [15:0] f_pos;
    logic        h_ready, h_start, h_enable, h_pulse, h_busy;
    logic [7:0]  h_value;
    logic [3:0]  h_phase;
    logic [15:0] h_pos;

    typedef struct packed {
        logic [3:0]  fph;
        logic [3:0]  hph;
        logic [15:0] pos;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    logic [3:0] full_t [0:3] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    logic [3:0] half_t [0:7] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
    logic [1:0]  m_f;
    logic [2:0]  m_h;
    logic [15:0] m_pos;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_start = 0;
    int last_pulse = -1;
    int exp_gap = 0;
    int period = 1;
    logic [7:0] exp_value = 8'd0;
    logic [15:0] cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    stepper_step_sequencer #(.HALF_STEP(1'b0)) u_full (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(f_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_delay(cmd_delay), .abort(abort),
        .dly_start(f_start), .dly_value(f_value), .dly_enable(f_enable), .dly_done(dly_done),
        .phase(f_phase), .step_pulse(f_pulse), .busy(f_busy), .position(f_pos)
    );

    stepper_step_sequencer #(.HALF_STEP(1'b1)) u_half (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(h_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_delay(cmd_delay), .abort(abort),
        .dly_start(h_start), .dly_value(h_value), .dly_enable(h_enable), .dly_done(dly_done),
        .phase(h_phase), .step_pulse(h_pulse), .busy(h_busy), .position(h_pos)
    );

    // delay counter model: value * period cycles of enable after the start strobe
    always @(posedge clk) begin
        if (reset) cnt <= 16'd0;
        else if (f_start) cnt <= 16'(int'(f_value) * period);
        else if (f_enable && cnt != 16'd0) cnt <= cnt - 16'd1;
    end
    assign dly_done = cnt == 16'd0;

    always @(negedge clk) begin
        if (!reset) begin
            if (f_start) begin
                n_start++;
                total++;
                if (f_value !== exp_value) begin
                    bad++;
                    $display("FAIL dly_value got=%h want=%h", f_value, exp_value);
                end
            end
            if (f_pulse) begin
                n_pulse++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_step_pulse at cycle %0d", cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (f_phase !== mon_e.fph || h_phase !== mon_e.hph || f_pos !== mon_e.pos || h_pos !== mon_e.pos || h_pulse !== 1'b1) begin
                        bad++;
                        $display("FAIL step_out got fph=%b hph=%b fpos=%h hpos=%h hpulse=%b want fph=%b hph=%b pos=%h",
                                 f_phase, h_phase, f_pos, h_pos, h_pulse, mon_e.fph, mon_e.hph, mon_e.pos);
                    end
                end
                if (last_pulse >= 0 && exp_gap != 0) begin
                    total++;
                    if (cyc - last_pulse != exp_gap) begin
                        bad++;
                        $display("FAIL pulse_gap got=%0d want=%0d", cyc - last_pulse, exp_gap);
                    end
                end
                last_pulse = cyc;
            end
        end
    end

    task automatic model_reset();
        m_f = 2'd0;
        m_h = 3'd0;
        m_pos = 16'd0;
        q.delete();
    endtask

    task automatic push_steps(input int n, input bit dir);
        for (int i = 0; i < n; i++) begin
            m_f = dir ? m_f + 2'd1 : m_f - 2'd1;
            m_h = dir ? m_h + 3'd1 : m_h - 3'd1;
            m_pos = dir ? m_pos + 16'd1 : m_pos - 16'd1;
            q.push_back('{full_t[m_f], half_t[m_h], m_pos});
        end
    endtask

    task automatic run_move(input int n, input bit dir, input logic [7:0] d, input int gap, output int bcyc);
        push_steps(n, dir);
        exp_gap = gap;
        exp_value = d;
        last_pulse = -1;
        n_start = 0;
        cmd_valid = 1'b1;
        cmd_steps = 8'(n);
        cmd_dir = dir;
        cmd_delay = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        bcyc = 0;
        while (f_busy && bcyc < 3000) begin
            bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({f_ready, f_busy, f_start, f_enable, f_pulse, f_phase, f_pos, f_value, h_phase, h_busy} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, 8'd0, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got ready=%b busy=%b start=%b en=%b pulse=%b ph=%b pos=%h val=%h hph=%b",
                     f_ready, f_busy, f_start, f_enable, f_pulse, f_phase, f_pos, f_value, h_phase);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_forward();
        int b;
        period = 1;
        run_move(5, 1'b1, 8'd0, 3, b);
        check_int("full_busy_cycles", b, 15);
        check_int("full_starts", n_start, 5);
        check_int("full_queue_left", q.size(), 0);
        check_int("full_position", int'(f_pos), 5);
        check_int("full_phase", int'(f_phase), 4'b0110);
        check_int("full_ready", int'(f_ready), 1);
    endtask

    task automatic test_half_reverse();
        int b;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_move(3, 1'b0, 8'd0, 3, b);
        check_int("half_busy_cycles", b, 9);
        check_int("half_phase", int'(h_phase), 4'b1100);
        check_int("half_position", int'(h_pos), 16'hFFFD);
        check_int("half_queue_left", q.size(), 0);
    endtask

    task automatic test_delay_counter();
        int b;
        period = 3;
        run_move(2, 1'b1, 8'd2, 9, b);
        check_int("delay_busy_cycles", b, 18);
        check_int("delay_starts", n_start, 2);
        check_int("delay_value_held", int'(f_value), 2);
        check_int("delay_queue_left", q.size(), 0);
        period = 1;
    endtask

    task automatic test_zero_steps();
        logic [3:0] ph;
        logic [15:0] pos;
        int np;
        ph = f_phase;
        pos = f_pos;
        np = n_pulse;
        cmd_valid = 1'b1;
        cmd_steps = 8'd0;
        cmd_dir = 1'b1;
        cmd_delay = 8'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_int("zero_busy", int'(f_busy), 0);
        repeat (3) @(negedge clk);
        check_int("zero_busy_later", int'(f_busy), 0);
        check_int("zero_phase", int'(f_phase), int'(ph));
        check_int("zero_position", int'(f_pos), int'(pos));
        check_int("zero_dly_value", int'(f_value), 2);
        check_int("zero_pulses", n_pulse, np);
    endtask

    task automatic test_abort();
        int c, np, b;
        np = n_pulse;
        push_steps(2, 1'b1);
        exp_gap = 6;
        exp_value = 8'd3;
        last_pulse = -1;
        cmd_valid = 1'b1;
        cmd_steps = 8'd10;
        cmd_dir = 1'b1;
        cmd_delay = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        c = 0;
        while (!(n_pulse - np == 2 && f_enable) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check_int("abort_reach_wait2", int'(c < 500), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_int("abort_idle", int'(f_ready), 1);
        check_int("abort_enable", int'(f_enable), 0);
        check_int("abort_position", int'(f_pos - (m_pos - 16'd2)), 2);
        check_int("abort_phase", int'(f_phase), int'(full_t[m_f]));
        repeat (8) @(negedge clk);
        check_int("abort_no_more_steps", n_pulse - np, 2);
        check_int("abort_queue_left", q.size(), 0);
        run_move(1, 1'b0, 8'd0, 0, b);
        check_int("post_abort_busy", b, 3);
        check_int("post_abort_position", int'(f_pos), int'(m_pos));
    endtask

    task automatic test_reset_mid_move();
        int c, np;
        np = n_pulse;
        push_steps(1, 1'b1);
        exp_gap = 0;
        exp_value = 8'd3;
        cmd_valid = 1'b1;
        cmd_steps = 8'd4;
        cmd_dir = 1'b1;
        cmd_delay = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        c = 0;
        while (!(n_pulse - np == 1 && f_enable) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check_int("mid_reach_wait", int'(c < 500), 1);
        cmd_valid = 1'b1;
        cmd_steps = 8'd7;
        cmd_dir = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_int("mid_ignored_cmd", int'(f_enable), 1);
        check_int("mid_ignored_pos", int'(f_pos), int'(m_pos));
        reset = 1'b1;
        #1;
        total++;
        if (f_phase !== 4'b0000 || f_pos !== 16'd0 || h_phase !== 4'b0000 || f_busy !== 1'b0 || f_enable !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got ph=%b pos=%h hph=%b busy=%b en=%b", f_phase, f_pos, h_phase, f_busy, f_enable);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        np = n_pulse;
        repeat (6) @(negedge clk);
        check_int("post_reset_busy", int'(f_busy), 0);
        check_int("post_reset_pulses", n_pulse - np, 0);
    endtask

    initial begin
        test_reset();
        test_full_forward();
        test_half_reverse();
        test_delay_counter();
        test_zero_steps();
        test_abort();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
